axi_sram_2m_arbiter: RTL and testbench

//  Two-master, one-slave AXI arbiter in front of the AXI-to-SRAM bridge.

---
 rtl/axi_sram_2m_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_sram_2m_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_2m_arbiter.sv
// Two-master / one-slave single-beat AXI arbiter in front of the SRAM bridge.
// Read and write paths have independent grant FSMs and round-robin pointers.
//
// state  | meaning
// W_IDLE | no write granted; sample s*_awvalid and register a grant
// W_XFER | granted master's AW and W routed to m_; waits for both handshakes
// W_RESP | m_ B routed back to the granted master
// R_IDLE | no read granted; sample s*_arvalid and register a grant
// R_ADDR | granted master's AR routed to m_
// R_DATA | m_ R routed back to the granted master; any beat is final
module axi_sram_2m_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic                s0_awvalid,
  output logic                s0_awready,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic                s0_wlast,
  input  logic                s0_wvalid,
  output logic                s0_wready,
  output logic [1:0]          s0_bresp,
  output logic                s0_bvalid,
  input  logic                s0_bready,
  input  logic [ADDR_W-1:0]   s0_araddr,
  input  logic                s0_arvalid,
  output logic                s0_arready,
  output logic [DATA_W-1:0]   s0_rdata,
  output logic [1:0]          s0_rresp,
  output logic                s0_rlast,
  output logic                s0_rvalid,
  input  logic                s0_rready,
  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic                s1_wlast,
  input  logic                s1_wvalid,
  output logic                s1_wready,
  output logic [1:0]          s1_bresp,
  output logic                s1_bvalid,
  input  logic                s1_bready,
  input  logic [ADDR_W-1:0]   s1_araddr,
  input  logic                s1_arvalid,
  output logic                s1_arready,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic [1:0]          s1_rresp,
  output logic                s1_rlast,
  output logic                s1_rvalid,
  input  logic                s1_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready
);

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;
  logic w_gnt, w_gnt_nxt, w_rr, w_rr_nxt;
  logic aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic r_gnt, r_gnt_nxt, r_rr, r_rr_nxt;
  logic aw_sel_valid, w_sel_valid, ar_sel_valid;

  // rr is the master that wins the next tie
  function automatic logic pick(input logic req0, input logic req1, input logic rr);
    if (req0 && req1) return (FIXED_PRIO != 0) ? 1'b0 : rr;
    return req1;
  endfunction

  assign aw_sel_valid = w_gnt ? s1_awvalid : s0_awvalid;
  assign w_sel_valid  = w_gnt ? s1_wvalid  : s0_wvalid;
  assign ar_sel_valid = r_gnt ? s1_arvalid : s0_arvalid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      w_gnt   <= 1'b0;
      w_rr    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      r_state <= R_IDLE;
      r_gnt   <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      w_gnt   <= w_gnt_nxt;
      w_rr    <= w_rr_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      r_state <= r_state_nxt;
      r_gnt   <= r_gnt_nxt;
      r_rr    <= r_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    w_gnt_nxt   = w_gnt;
    w_rr_nxt    = w_rr;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    m_awaddr    = '0;
    m_awvalid   = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wlast     = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    s0_awready  = 1'b0;
    s1_awready  = 1'b0;
    s0_wready   = 1'b0;
    s1_wready   = 1'b0;
    s0_bvalid   = 1'b0;
    s1_bvalid   = 1'b0;
    s0_bresp    = '0;
    s1_bresp    = '0;
    case (w_state)
      W_IDLE: begin
        if (s0_awvalid || s1_awvalid) begin
          w_gnt_nxt   = pick(s0_awvalid, s1_awvalid, w_rr);
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          w_state_nxt = W_XFER;
        end
      end
      W_XFER: begin
        m_awaddr   = w_gnt ? s1_awaddr : s0_awaddr;
        m_awvalid  = aw_sel_valid & ~aw_done;
        m_wdata    = w_gnt ? s1_wdata : s0_wdata;
        m_wstrb    = w_gnt ? s1_wstrb : s0_wstrb;
        m_wlast    = w_gnt ? s1_wlast : s0_wlast;
        m_wvalid   = w_sel_valid & ~w_done;
        s0_awready = ~w_gnt & ~aw_done & m_awready;
        s1_awready =  w_gnt & ~aw_done & m_awready;
        s0_wready  = ~w_gnt & ~w_done & m_wready;
        s1_wready  =  w_gnt & ~w_done & m_wready;
        // AW and W may complete in either order or together
        if (aw_sel_valid && !aw_done && m_awready) aw_done_nxt = 1'b1;
        if (w_sel_valid && !w_done && m_wready) w_done_nxt = 1'b1;
        if (aw_done_nxt && w_done_nxt) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        m_bready  = w_gnt ? s1_bready : s0_bready;
        s0_bvalid = ~w_gnt & m_bvalid;
        s1_bvalid =  w_gnt & m_bvalid;
        s0_bresp  = w_gnt ? 2'b00 : m_bresp;
        s1_bresp  = w_gnt ? m_bresp : 2'b00;
        if (m_bvalid && m_bready) begin
          w_rr_nxt    = ~w_gnt;
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    r_gnt_nxt   = r_gnt;
    r_rr_nxt    = r_rr;
    m_araddr    = '0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    s0_arready  = 1'b0;
    s1_arready  = 1'b0;
    s0_rvalid   = 1'b0;
    s1_rvalid   = 1'b0;
    s0_rdata    = '0;
    s1_rdata    = '0;
    s0_rresp    = '0;
    s1_rresp    = '0;
    s0_rlast    = 1'b0;
    s1_rlast    = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (s0_arvalid || s1_arvalid) begin
          r_gnt_nxt   = pick(s0_arvalid, s1_arvalid, r_rr);
          r_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        m_araddr   = r_gnt ? s1_araddr : s0_araddr;
        m_arvalid  = ar_sel_valid;
        s0_arready = ~r_gnt & m_arready;
        s1_arready =  r_gnt & m_arready;
        if (ar_sel_valid && m_arready) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        m_rready  = r_gnt ? s1_rready : s0_rready;
        s0_rvalid = ~r_gnt & m_rvalid;
        s1_rvalid =  r_gnt & m_rvalid;
        s0_rdata  = r_gnt ? '0 : m_rdata;
        s1_rdata  = r_gnt ? m_rdata : '0;
        s0_rresp  = r_gnt ? 2'b00 : m_rresp;
        s1_rresp  = r_gnt ? m_rresp : 2'b00;
        s0_rlast  = ~r_gnt & m_rlast;
        s1_rlast  =  r_gnt & m_rlast;
        // single-beat contract: the first beat ends the read whatever rlast says
        if (m_rvalid && m_rready) begin
          r_rr_nxt    = ~r_gnt;
          r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_2m_arbiter.sv
// Bench for axi_sram_2m_arbiter: behavioural SRAM bridge on m_, two master tasks,
// and a reference memory / round-robin model checked with immediate assertions.
`timescale 1ns/1ps
module tb_axi_sram_2m_arbiter;
  localparam int FP = 0;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [1:0][31:0] awaddr_d, araddr_d;
  logic [1:0][63:0] wdata_d;
  logic [1:0][7:0]  wstrb_d;
  logic [1:0]       awvalid_d, wvalid_d, wlast_d, bready_d, arvalid_d, rready_d;
  logic [1:0]       awready_o, wready_o, bvalid_o, arready_o, rvalid_o, rlast_o;
  logic [1:0][1:0]  bresp_o, rresp_o;
  logic [1:0][63:0] rdata_o;

  logic [31:0] m_awaddr, m_araddr;
  logic [63:0] m_wdata, m_rdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;

  axi_sram_2m_arbiter #(.ADDR_W(32), .DATA_W(64), .FIXED_PRIO(FP)) dut (
    .clk(clk), .resetn(resetn),
    .s0_awaddr(awaddr_d[0]), .s0_awvalid(awvalid_d[0]), .s0_awready(awready_o[0]),
    .s0_wdata(wdata_d[0]), .s0_wstrb(wstrb_d[0]), .s0_wlast(wlast_d[0]),
    .s0_wvalid(wvalid_d[0]), .s0_wready(wready_o[0]),
    .s0_bresp(bresp_o[0]), .s0_bvalid(bvalid_o[0]), .s0_bready(bready_d[0]),
    .s0_araddr(araddr_d[0]), .s0_arvalid(arvalid_d[0]), .s0_arready(arready_o[0]),
    .s0_rdata(rdata_o[0]), .s0_rresp(rresp_o[0]), .s0_rlast(rlast_o[0]),
    .s0_rvalid(rvalid_o[0]), .s0_rready(rready_d[0]),
    .s1_awaddr(awaddr_d[1]), .s1_awvalid(awvalid_d[1]), .s1_awready(awready_o[1]),
    .s1_wdata(wdata_d[1]), .s1_wstrb(wstrb_d[1]), .s1_wlast(wlast_d[1]),
    .s1_wvalid(wvalid_d[1]), .s1_wready(wready_o[1]),
    .s1_bresp(bresp_o[1]), .s1_bvalid(bvalid_o[1]), .s1_bready(bready_d[1]),
    .s1_araddr(araddr_d[1]), .s1_arvalid(arvalid_d[1]), .s1_arready(arready_o[1]),
    .s1_rdata(rdata_o[1]), .s1_rresp(rresp_o[1]), .s1_rlast(rlast_o[1]),
    .s1_rvalid(rvalid_o[1]), .s1_rready(rready_d[1]),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // handshakes and payloads sampled at the active edge, consumed at the following negedge
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, cap_wlast;
  logic [31:0] cap_awaddr, cap_araddr;
  logic [63:0] cap_wdata;
  logic [7:0]  cap_wstrb;
  logic [1:0]  s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs, cap_rlast;
  logic [1:0][1:0]  cap_bresp, cap_rresp;
  logic [1:0][63:0] cap_rdata;
  logic [1:0] pend_b = '0, pend_r = '0;
  int route_err = 0;
  int r_cnt0 = 0, r_cnt1 = 0;

  always @(posedge clk) begin
    aw_hs      <= m_awvalid & m_awready;
    cap_awaddr <= m_awaddr;
    w_hs       <= m_wvalid & m_wready;
    cap_wdata  <= m_wdata;
    cap_wstrb  <= m_wstrb;
    cap_wlast  <= m_wlast;
    b_hs       <= m_bvalid & m_bready;
    ar_hs      <= m_arvalid & m_arready;
    cap_araddr <= m_araddr;
    r_hs       <= m_rvalid & m_rready;
    s_aw_hs    <= awvalid_d & awready_o;
    s_w_hs     <= wvalid_d & wready_o;
    s_b_hs     <= bvalid_o & bready_d;
    s_ar_hs    <= arvalid_d & arready_o;
    s_r_hs     <= rvalid_o & rready_d;
    cap_bresp  <= bresp_o;
    cap_rresp  <= rresp_o;
    cap_rdata  <= rdata_o;
    cap_rlast  <= rlast_o;
    route_err  <= route_err + $countones(bvalid_o & ~pend_b) + $countones(rvalid_o & ~pend_r);
    if (rvalid_o[0] && rready_d[0]) r_cnt0 <= r_cnt0 + 1;
    if (rvalid_o[1] && rready_d[1]) r_cnt1 <= r_cnt1 + 1;
  end

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // behavioural bridge + SRAM
  logic [63:0] bmem [logic [31:0]];
  logic [31:0] aw_log [$];
  int aw_tot = 0, w_tot = 0;
  int aw_delay = 0, w_delay = 0, ar_delay = 0;
  int aw_wait, w_wait, ar_wait;
  logic aw_have, w_have, last_wlast, last_rlast;
  logic [31:0] aw_a;
  logic [63:0] w_d;
  logic [7:0]  w_s;
  logic [1:0]  last_bresp, last_rresp;

  initial begin
    {m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rlast} = '0;
    m_bresp = '0; m_rresp = '0; m_rdata = '0;
    aw_have = 0; w_have = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
    aw_a = '0; w_d = '0; w_s = '0; last_wlast = 0; last_rlast = 0;
    last_bresp = '0; last_rresp = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
        aw_have = 0; w_have = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
      end else begin
        if (aw_hs) begin aw_have = 1; aw_a = cap_awaddr; aw_log.push_back(cap_awaddr); aw_tot++; aw_wait = 0; end
        if (w_hs) begin w_have = 1; w_d = cap_wdata; w_s = cap_wstrb; last_wlast = cap_wlast; w_tot++; w_wait = 0; end
        if (b_hs) m_bvalid = 0;
        if (aw_have && w_have && !m_bvalid) begin
          bmem[aw_a] = merge(bmem.exists(aw_a) ? bmem[aw_a] : 64'd0, w_d, w_s);
          m_bresp = 2'($urandom_range(0, 3));
          last_bresp = m_bresp;
          m_bvalid = 1; aw_have = 0; w_have = 0;
        end
        if (r_hs) m_rvalid = 0;
        if (ar_hs) begin
          m_rdata = bmem.exists(cap_araddr) ? bmem[cap_araddr] : 64'd0;
          m_rresp = 2'($urandom_range(0, 3));
          m_rlast = 1'($urandom_range(0, 1));
          last_rresp = m_rresp; last_rlast = m_rlast;
          m_rvalid = 1; ar_wait = 0;
        end
        m_awready = 0;
        if (m_awvalid && !aw_have) begin if (aw_wait >= aw_delay) m_awready = 1; else aw_wait++; end
        m_wready = 0;
        if (m_wvalid && !w_have) begin if (w_wait >= w_delay) m_wready = 1; else w_wait++; end
        m_arready = 0;
        if (m_arvalid && !m_rvalid) begin if (ar_wait >= ar_delay) m_arready = 1; else ar_wait++; end
      end
    end
  end

  // reference model: memory contents and write round-robin pointer
  logic [63:0] ref_mem [logic [31:0]];
  int rr_w = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] vr_vec();
    return {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
            awready_o, wready_o, bvalid_o, arready_o, rvalid_o};
  endfunction

  task automatic do_write(input int m, input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] s, input int bdelay);
    int n, held;
    logic aw_ok, w_ok, got;
    @(negedge clk);
    awaddr_d[m] = a; wdata_d[m] = d; wstrb_d[m] = s; wlast_d[m] = 1;
    awvalid_d[m] = 1; wvalid_d[m] = 1; bready_d[m] = (bdelay == 0); pend_b[m] = 1;
    aw_ok = 0; w_ok = 0; n = 0;
    while (!(aw_ok && w_ok) && n < 300) begin
      @(negedge clk); n++;
      if (s_aw_hs[m]) begin aw_ok = 1; awvalid_d[m] = 0; end
      if (s_w_hs[m]) begin w_ok = 1; wvalid_d[m] = 0; end
    end
    awvalid_d[m] = 0; wvalid_d[m] = 0;
    chk("wr_aw_w_done", 64'({aw_ok, w_ok}), 64'd3);
    got = 0; held = 0; n = 0;
    while (!got && n < 300) begin
      @(negedge clk); n++;
      if (s_b_hs[m]) got = 1;
      else if (bvalid_o[m]) begin if (held >= bdelay) bready_d[m] = 1; else held++; end
    end
    bready_d[m] = 0; pend_b[m] = 0; wlast_d[m] = 0;
    chk("wr_b_done", 64'(got), 64'd1);
    chk("wr_bresp", 64'(cap_bresp[m]), 64'(last_bresp));
    chk("wr_wlast", 64'(last_wlast), 64'd1);
    ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : 64'd0, d, s);
    rr_w = 1 - m;
  endtask

  task automatic do_read(input int m, input logic [31:0] a, input int rdelay);
    int n, held;
    logic got;
    @(negedge clk);
    araddr_d[m] = a; arvalid_d[m] = 1; rready_d[m] = (rdelay == 0); pend_r[m] = 1;
    n = 0;
    while (!s_ar_hs[m] && n < 300) begin @(negedge clk); n++; end
    arvalid_d[m] = 0;
    chk("rd_ar_done", 64'(s_ar_hs[m]), 64'd1);
    got = 0; held = 0; n = 0;
    while (!got && n < 300) begin
      @(negedge clk); n++;
      if (s_r_hs[m]) got = 1;
      else if (rvalid_o[m]) begin if (held >= rdelay) rready_d[m] = 1; else held++; end
    end
    rready_d[m] = 0; pend_r[m] = 0;
    chk("rd_done", 64'(got), 64'd1);
    chk("rd_data", cap_rdata[m], ref_mem.exists(a) ? ref_mem[a] : 64'd0);
    chk("rd_held_cycles", 64'(held), 64'(rdelay));
    chk("rd_rresp", 64'(cap_rresp[m]), 64'(last_rresp));
    chk("rd_rlast", 64'(cap_rlast[m]), 64'(last_rlast));
  endtask

  task automatic do_tie(input logic [31:0] a0, input logic [31:0] a1);
    int n, first;
    n = aw_log.size();
    first = (FP != 0) ? 0 : rr_w;
    fork
      do_write(0, a0, {$urandom, $urandom}, 8'hff, 0);
      do_write(1, a1, {$urandom, $urandom}, 8'hff, 1);
    join
    chk("tie_count", 64'(aw_log.size() - n), 64'd2);
    if (aw_log.size() >= n + 2) begin
      chk("tie_first", 64'(aw_log[n]), 64'(first == 0 ? a0 : a1));
      chk("tie_second", 64'(aw_log[n+1]), 64'(first == 0 ? a1 : a0));
    end
  endtask

  task automatic rand_op(input int m, input int op, input logic [31:0] wa, input logic [31:0] ra,
                         input logic [63:0] d, input logic [7:0] s, input int dly);
    if (op == 1) do_write(m, wa, d, s, dly);
    else if (op == 2) do_read(m, ra, dly);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rc0, rc1;
    logic [31:0] wq0 [$];
    logic [31:0] wq1 [$];
    awaddr_d = '0; araddr_d = '0; wdata_d = '0; wstrb_d = '0;
    awvalid_d = '0; wvalid_d = '0; wlast_d = '0; bready_d = '0; arvalid_d = '0; rready_d = '0;
    resetn = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid_ready", 64'(vr_vec()), 64'd0);
    chk("rst_m_awaddr", 64'(m_awaddr), 64'd0);
    chk("rst_s_rdata", rdata_o[0] | rdata_o[1], 64'd0);
    resetn = 1;
    @(negedge clk);

    n = aw_tot; rc0 = w_tot;
    do_write(0, 32'h4, 64'habcdaaaa12345678, 8'hff, 0);
    chk("w1_single_aw", 64'(aw_tot - n), 64'd1);
    chk("w1_single_w", 64'(w_tot - rc0), 64'd1);

    // reset while the write sits in the response phase
    @(negedge clk);
    awaddr_d[0] = 32'h40; wdata_d[0] = 64'h1111; wstrb_d[0] = 8'hff; wlast_d[0] = 1;
    awvalid_d[0] = 1; wvalid_d[0] = 1; pend_b[0] = 1; n = 0;
    while (!bvalid_o[0] && n < 50) begin
      @(negedge clk); n++;
      if (s_aw_hs[0]) awvalid_d[0] = 0;
      if (s_w_hs[0]) wvalid_d[0] = 0;
    end
    chk("resp_phase_bvalid", 64'(bvalid_o[0]), 64'd1);
    resetn = 0;
    #1;
    chk("rst_mid_valid_ready", 64'(vr_vec()), 64'd0);
    awvalid_d = '0; wvalid_d = '0; wlast_d = '0; bready_d[0] = 1;
    @(posedge clk); #1;
    chk("rst_held_valid_ready", 64'(vr_vec()), 64'd0);
    repeat (3) @(negedge clk);
    bready_d[0] = 0; pend_b[0] = 0; rr_w = 0;
    ref_mem[32'h40] = 64'h1111;
    resetn = 1;

    do_tie(32'h8, 32'h10);
    do_write(0, 32'h18, 64'h0123456789abcdef, 8'hff, 2);
    do_tie(32'h28, 32'h30);

    rc0 = r_cnt0; rc1 = r_cnt1;
    do_read(1, 32'h4, 5);
    chk("rd_once_s1", 64'(r_cnt1 - rc1), 64'd1);
    chk("rd_none_s0", 64'(r_cnt0 - rc0), 64'd0);

    fork
      do_write(0, 32'h20, 64'hfeedface_c0ffee00, 8'hff, 1);
      do_read(1, 32'h4, 2);
    join
    do_read(0, 32'h20, 0);

    n = aw_tot; rc0 = w_tot;
    aw_delay = 3; w_delay = 0;
    do_write(1, 32'h38, 64'h5a5a_a5a5_0f0f_f0f0, 8'h3c, 0);
    aw_delay = 0;
    chk("wfirst_single_aw", 64'(aw_tot - n), 64'd1);
    chk("wfirst_single_w", 64'(w_tot - rc0), 64'd1);
    do_read(0, 32'h38, 1);

    for (int it = 0; it < 30; it++) begin
      int op0, op1, d0, d1;
      logic [31:0] wa0, wa1, ra0, ra1;
      op0 = $urandom_range(0, 2); op1 = $urandom_range(0, 2);
      if (op0 == 2 && wq0.size() == 0) op0 = 1;
      if (op1 == 2 && wq1.size() == 0) op1 = 1;
      wa0 = 32'h100 + 32'(8 * $urandom_range(0, 7));
      wa1 = 32'h200 + 32'(8 * $urandom_range(0, 7));
      ra0 = (wq0.size() != 0) ? wq0[$urandom_range(0, wq0.size() - 1)] : 32'h0;
      ra1 = (wq1.size() != 0) ? wq1[$urandom_range(0, wq1.size() - 1)] : 32'h0;
      d0 = $urandom_range(0, 3); d1 = $urandom_range(0, 3);
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      fork
        rand_op(0, op0, wa0, ra0, {$urandom, $urandom}, 8'($urandom_range(1, 255)), d0);
        rand_op(1, op1, wa1, ra1, {$urandom, $urandom}, 8'($urandom_range(1, 255)), d1);
      join
      if (op0 == 1) wq0.push_back(wa0);
      if (op1 == 1) wq1.push_back(wa1);
    end

    repeat (2) @(negedge clk);
    chk("no_cross_routing", 64'(route_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
